edge_ctrl: RTL and testbench
============================

Name: edge_ctrl

Overview:
- Frame-synchronous controller for the edge-detect datapath.
- Holds software-visible control registers (enable, mode, threshold) behind a simple register port.
- Applies them to the edge detector only at frame boundaries, sequences continuous and single-shot runs, and counts edge pixels per frame.
- Sits between the SoC register bus and the edge-detect stage of the video pipeline.

Parameters:
- IMG_HDISP, 11'd1280, active pixels per line.
- IMG_VDISP, 11'd720, active lines per frame.
- CNT_W, 20, edge-count width; must hold IMG_HDISP*IMG_VDISP.

Ports:
- clk  in  1  video pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  register write strobe, one cycle
- wr_addr  in  3  write address
- wr_data  in  32  write data
- rd_addr  in  3  read address
- rd_data  out  32  read data, combinational from rd_addr
- pre_vs  in  1  frame sync at the detector input; high = vertical blanking
- post_vs  in  1  detector output vs
- post_de  in  1  detector output de
- post_bit  in  1  detector edge flag
- EN  out  1  detector enable (shadow)
- mode  out  2  detector mode (shadow): 0 Sobel, 1 Prewitt
- threshold  out  8  detector threshold (shadow)
- frame_done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset values: EN=0, mode=0, threshold=8'd64, frame_done=0, rd_data=0.
- Reset values, internal: all registers and counters 0 except THRESH=64; state IDLE.
- Registers:
  - 0 CTRL: bit0 enable, bits2:1 mode, bit3 single-shot.
  - 1 THRESH [7:0].
  - 2 EDGE_CNT, RO, last frame's count.
  - 3 FRAME_CNT, RO, 32-bit, wraps.
  - 4 TGT_LO, 5 TGT_HI: CNT_W bits each; used only with the optional feature.
- Unmapped address reads return 0; writes to RO or unmapped addresses are ignored.
- Register write timing: a write lands at the next clock edge.
- Frame boundary = rising edge of pre_vs, detected with a 1-cycle registered copy.
- Frame end = rising edge of post_vs.
- FSM IDLE:
  - EN output held 0.
  - Go to ARM when CTRL.enable=1.
- FSM ARM:
  - At the frame boundary: load shadow regs (EN=1, mode, threshold), clear the pixel counter, go to RUN.
  - If CTRL.enable is cleared before the boundary, return to IDLE.
- FSM RUN:
  - Counter increments each cycle post_de&post_bit=1; saturates at all-ones.
  - At frame end: EDGE_CNT<=counter, FRAME_CNT+=1, frame_done=1 for one cycle, go to DONE.
- FSM DONE, one cycle:
  - If single-shot: clear CTRL.enable, go to IDLE.
  - Otherwise, if CTRL.enable=1 go to ARM, else go to IDLE.
  - EN stays 1 until the next boundary (ARM) or until IDLE is entered.
- Continuous mode: shadow values reload at every frame boundary; mid-frame register writes never alter EN/mode/threshold outputs.
- Write in the same cycle as a frame boundary: the shadow loads the pre-write value; the new value takes effect at the following boundary.
- Frame end and post_de&post_bit in the same cycle: the pixel is counted before latching.
- A frame boundary seen in RUN without a frame end (truncated frame): reload shadows, restart the counter, no frame_done.
- Asserting rst_n mid-frame: immediate return to reset values.

Optional Feature:
- Macro: EDGE_AUTO_TH_EN.
- With the macro, in DONE using the latched EDGE_CNT:
  - Count > TGT_HI: THRESH+=4, saturating at 255.
  - Count < TGT_LO: THRESH-=4, saturating at 1.
  - Otherwise THRESH is unchanged.
  - A software write to THRESH in the same cycle wins.
- Without the macro: THRESH changes only by software write; TGT_LO/TGT_HI read as 0 and writes to them are ignored.

Decomposition:
- Package edge_ctrl_pkg:
  - Register address constants.
  - FSM state encoding: IDLE, ARM, RUN, DONE.
  - Auto-threshold step constant (4).
  - Reset threshold constant (64).
- One sub-module, edge_pix_counter:
  - Saturating CNT_W counter.
  - Inputs: clr, inc, latch.
  - Outputs: live count and latched count.

Test Plan:
- Write CTRL=0x1, THRESH=0x30; drive pre_vs pulse -> EN=1 and threshold=0x30 the cycle after the pre_vs rising edge, not before.
- Full frame with post_bit high on 1000 de cycles, then post_vs rise -> EDGE_CNT=1000, FRAME_CNT=1, one frame_done pulse.
- Write THRESH=0x80 mid-frame in continuous mode -> threshold output stays 0x30 until the next pre_vs rise, then 0x80.
- CTRL=0x9 (single-shot) -> one frame counted, then CTRL.enable reads 0, EN=0, no second frame_done.
- Assert rst_n low mid-RUN -> EN=0, threshold=64, EDGE_CNT=0, state IDLE.
- With EDGE_AUTO_TH_EN: TGT_HI=500, frame count 1000, THRESH=254 -> THRESH=255 after DONE; next frame THRESH stays 255.

Source files
------------

// File: rtl/edge_ctrl_pkg.sv
// Shared constants, FSM encoding and threshold helper for the edge-detect controller.
package edge_ctrl_pkg;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_THRESH    = 3'd1;
    localparam logic [2:0] ADDR_EDGE_CNT  = 3'd2;
    localparam logic [2:0] ADDR_FRAME_CNT = 3'd3;
    localparam logic [2:0] ADDR_TGT_LO    = 3'd4;
    localparam logic [2:0] ADDR_TGT_HI    = 3'd5;

    localparam logic [7:0] THRESH_RST = 8'd64;
    localparam logic [7:0] AUTO_STEP  = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Step the threshold up or down, clamped to [1, 255].
    function automatic logic [7:0] auto_thresh(input logic [7:0] cur,
                                               input logic up,
                                               input logic down);
        auto_thresh = cur;
        if (up)
            auto_thresh = (cur > 8'd255 - AUTO_STEP) ? 8'd255 : cur + AUTO_STEP;
        else if (down)
            auto_thresh = (cur < 8'd1 + AUTO_STEP) ? 8'd1 : cur - AUTO_STEP;
    endfunction

endpackage

// File: rtl/edge_ctrl_pix_counter.sv
// Saturating edge-pixel counter with a latched copy; a latch captures the
// count including a pixel arriving in the same cycle.
module edge_pix_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             latch,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] latched
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] latched_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != '1))
            count_next = count_reg + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            latched_reg <= '0;
        end else begin
            count_reg <= clr ? '0 : count_next;
            if (latch)
                latched_reg <= count_next;
        end
    end

    assign count   = count_reg;
    assign latched = latched_reg;

endmodule

// File: rtl/edge_ctrl.sv
// Frame-synchronous control registers and run sequencer for the edge detector.
// Optional EDGE_AUTO_TH_EN: per-frame automatic threshold tracking toward TGT_LO..TGT_HI.
module edge_ctrl
    import edge_ctrl_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd1280,
    parameter logic [10:0] IMG_VDISP = 11'd720,
    parameter int          CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        pre_vs,
    input  logic        post_vs,
    input  logic        post_de,
    input  logic        post_bit,
    output logic        EN,
    output logic [1:0]  mode,
    output logic [7:0]  threshold,
    output logic        frame_done
);
    generate
        if (CNT_W < $clog2(32'(IMG_HDISP) * 32'(IMG_VDISP) + 1)) begin : g_cnt_w_check
            $error("CNT_W cannot hold a full frame of edge pixels");
        end
    endgenerate

    state_t state_reg, state_next;

    logic        pre_vs_d_reg, post_vs_d_reg;
    logic        ctrl_en_reg, ctrl_single_reg;
    logic [1:0]  ctrl_mode_reg;
    logic [7:0]  thresh_reg;
    logic [31:0] frame_cnt_reg;
    logic        en_reg;
    logic [1:0]  mode_reg;
    logic [7:0]  thr_sh_reg;

    logic boundary, frame_end;
    logic load_sh, cnt_clr, cnt_inc, cnt_latch, clear_en, auto_adj;
    logic [CNT_W-1:0] cnt_live, edge_cnt;

    assign boundary  = pre_vs & ~pre_vs_d_reg;
    assign frame_end = post_vs & ~post_vs_d_reg;

`ifdef EDGE_AUTO_TH_EN
    logic [CNT_W-1:0] tgt_lo_reg, tgt_hi_reg;
`endif

    always_comb begin
        state_next = state_reg;
        load_sh    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        cnt_latch  = 1'b0;
        clear_en   = 1'b0;
        auto_adj   = 1'b0;
        case (state_reg)
            ST_IDLE: if (ctrl_en_reg) state_next = ST_ARM;
            ST_ARM: begin
                if (!ctrl_en_reg) begin
                    state_next = ST_IDLE;
                end else if (boundary) begin
                    load_sh    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_inc = post_de & post_bit;
                if (frame_end) begin
                    cnt_latch  = 1'b1;
                    state_next = ST_DONE;
                end else if (boundary) begin
                    // Truncated frame: restart without reporting.
                    load_sh = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            ST_DONE: begin
                auto_adj = 1'b1;
                if (ctrl_single_reg) begin
                    clear_en   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ctrl_en_reg ? ST_ARM : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pre_vs_d_reg  <= 1'b0;
            post_vs_d_reg <= 1'b0;
            frame_cnt_reg <= '0;
            en_reg        <= 1'b0;
            mode_reg      <= 2'd0;
            thr_sh_reg    <= THRESH_RST;
        end else begin
            state_reg     <= state_next;
            pre_vs_d_reg  <= pre_vs;
            post_vs_d_reg <= post_vs;
            if (cnt_latch)
                frame_cnt_reg <= frame_cnt_reg + 32'd1;
            if (load_sh) begin
                en_reg     <= 1'b1;
                mode_reg   <= ctrl_mode_reg;
                thr_sh_reg <= thresh_reg;
            end else if (state_next == ST_IDLE) begin
                en_reg <= 1'b0;
            end
        end
    end

    // Software writes take priority over single-shot clear and auto-threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_reg     <= 1'b0;
            ctrl_mode_reg   <= 2'd0;
            ctrl_single_reg <= 1'b0;
            thresh_reg      <= THRESH_RST;
`ifdef EDGE_AUTO_TH_EN
            tgt_lo_reg      <= '0;
            tgt_hi_reg      <= '0;
`endif
        end else begin
            if (clear_en)
                ctrl_en_reg <= 1'b0;
`ifdef EDGE_AUTO_TH_EN
            if (auto_adj)
                thresh_reg <= auto_thresh(thresh_reg, edge_cnt > tgt_hi_reg,
                                          edge_cnt < tgt_lo_reg);
`endif
            if (wr_en) begin
                case (wr_addr)
                    ADDR_CTRL: begin
                        ctrl_en_reg     <= wr_data[0];
                        ctrl_mode_reg   <= wr_data[2:1];
                        ctrl_single_reg <= wr_data[3];
                    end
                    ADDR_THRESH: thresh_reg <= wr_data[7:0];
`ifdef EDGE_AUTO_TH_EN
                    ADDR_TGT_LO: tgt_lo_reg <= wr_data[CNT_W-1:0];
                    ADDR_TGT_HI: tgt_hi_reg <= wr_data[CNT_W-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    edge_pix_counter #(.CNT_W(CNT_W)) u_pix_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .latch   (cnt_latch),
        .count   (cnt_live),
        .latched (edge_cnt)
    );

    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            ADDR_CTRL:      rd_data = {28'd0, ctrl_single_reg, ctrl_mode_reg, ctrl_en_reg};
            ADDR_THRESH:    rd_data = {24'd0, thresh_reg};
            ADDR_EDGE_CNT:  rd_data = 32'(edge_cnt);
            ADDR_FRAME_CNT: rd_data = frame_cnt_reg;
`ifdef EDGE_AUTO_TH_EN
            ADDR_TGT_LO:    rd_data = 32'(tgt_lo_reg);
            ADDR_TGT_HI:    rd_data = 32'(tgt_hi_reg);
`else
            ADDR_TGT_LO:    rd_data = 32'd0;
            ADDR_TGT_HI:    rd_data = 32'd0;
`endif
            default:        rd_data = 32'd0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{wr_data[31:8], cnt_live};

    assign EN         = en_reg;
    assign mode       = mode_reg;
    assign threshold  = thr_sh_reg;
    assign frame_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_edge_ctrl.sv
// Randomised and directed bench for edge_ctrl against a frame-level behavioural model.
module tb_edge_ctrl;
    localparam int CNT_W = 20;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n, wr_en, pre_vs, post_vs, post_de, post_bit;
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic        EN, frame_done;
    logic [1:0]  mode;
    logic [7:0]  threshold;

    always #5 clk = ~clk;

    edge_ctrl #(.IMG_HDISP(11'd1280), .IMG_VDISP(11'd720), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .pre_vs(pre_vs), .post_vs(post_vs),
        .post_de(post_de), .post_bit(post_bit), .EN(EN), .mode(mode),
        .threshold(threshold), .frame_done(frame_done)
    );

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;

    // Model: software registers, detector-facing shadows, and run progress.
    bit          m_enable, m_single, m_armed, m_running, m_in_done, m_done;
    bit [1:0]    m_mode, m_mode_o;
    bit [7:0]    m_thresh, m_thr_o;
    bit          m_en_o, m_prev_pre, m_prev_post;
    int          m_count, m_edge;
    bit [31:0]   m_frames;
    int          m_tgt_lo, m_tgt_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {28'd0, m_single, m_mode, m_enable};
            3'd1: return {24'd0, m_thresh};
            3'd2: return 32'(m_edge);
            3'd3: return m_frames;
`ifdef EDGE_AUTO_TH_EN
            3'd4: return 32'(m_tgt_lo);
            3'd5: return 32'(m_tgt_hi);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_enable = 0; m_single = 0; m_mode = 0; m_thresh = 8'd64;
        m_armed = 0; m_running = 0; m_in_done = 0; m_done = 0;
        m_en_o = 0; m_mode_o = 0; m_thr_o = 8'd64;
        m_prev_pre = 0; m_prev_post = 0;
        m_count = 0; m_edge = 0; m_frames = 0; m_tgt_lo = 0; m_tgt_hi = 0;
    endtask

    task automatic load_shadows();
        m_en_o = 1; m_mode_o = m_mode; m_thr_o = m_thresh; m_count = 0;
    endtask

    task automatic model_step();
        bit bnd, fe, pix, was_idle;
        int t;
        bnd = pre_vs && !m_prev_pre;
        fe  = post_vs && !m_prev_post;
        pix = post_de && post_bit;
        was_idle = !m_armed && !m_running && !m_in_done;
        m_done = 0;
        if (m_in_done) begin
            m_in_done = 0;
`ifdef EDGE_AUTO_TH_EN
            if (m_edge > m_tgt_hi) begin
                t = int'(m_thresh) + 4; m_thresh = (t > 255) ? 8'd255 : 8'(t);
            end else if (m_edge < m_tgt_lo) begin
                t = int'(m_thresh) - 4; m_thresh = (t < 1) ? 8'd1 : 8'(t);
            end
`endif
            if (m_single) m_enable = 0;
            else if (m_enable) m_armed = 1;
            if (!m_armed) m_en_o = 0;
        end else if (m_running) begin
            if (fe) begin
                t = m_count + int'(pix);
                m_edge = (t > MAXC) ? MAXC : t;
                m_frames = m_frames + 1;
                m_done = 1; m_in_done = 1; m_running = 0;
            end else if (bnd) begin
                load_shadows();
            end else begin
                t = m_count + int'(pix);
                m_count = (t > MAXC) ? MAXC : t;
            end
        end else if (m_armed) begin
            if (!m_enable) begin
                m_armed = 0; m_en_o = 0;
            end else if (bnd) begin
                load_shadows(); m_armed = 0; m_running = 1;
            end
        end else if (was_idle && m_enable) begin
            m_armed = 1;
        end
        if (wr_en) begin
            case (wr_addr)
                3'd0: begin m_enable = wr_data[0]; m_mode = wr_data[2:1]; m_single = wr_data[3]; end
                3'd1: m_thresh = wr_data[7:0];
`ifdef EDGE_AUTO_TH_EN
                3'd4: m_tgt_lo = int'(wr_data[CNT_W-1:0]);
                3'd5: m_tgt_hi = int'(wr_data[CNT_W-1:0]);
`endif
                default: ;
            endcase
        end
        m_prev_pre = pre_vs; m_prev_post = post_vs;
    endtask

    task automatic compare_all();
        check("EN", 32'(EN), 32'(m_en_o));
        check("mode", 32'(mode), 32'(m_mode_o));
        check("threshold", 32'(threshold), 32'(m_thr_o));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("rd_data", rd_data, model_read(rd_addr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        vectors++;
        if (frame_done) done_seen++;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic pixels(input int n, input bit b);
        post_de = 1; post_bit = b;
        repeat (n) tick();
        post_de = 0; post_bit = 0;
    endtask

    task automatic pulse_pre();
        pre_vs = 1; tick(); pre_vs = 0; tick();
    endtask

    task automatic pulse_post();
        post_vs = 1; tick(); post_vs = 0; tick();
    endtask

    int d0;

    initial begin
        rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
        pre_vs = 0; post_vs = 0; post_de = 0; post_bit = 0;
        model_reset();
        @(negedge clk);
        check("rst_EN", 32'(EN), 32'd0);
        check("rst_threshold", 32'(threshold), 32'd64);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_rd_ctrl", rd_data, 32'd0);
        rd_addr = 3'd1; #1;
        check("rst_rd_thresh", rd_data, 32'd64);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Shadow load lands the cycle after the pre_vs rise.
        reg_write(3'd0, 32'h1);
        reg_write(3'd1, 32'h30);
        pre_vs = 1; #1;
        check("EN_before_boundary", 32'(EN), 32'd0);
        tick();
        check("EN_after_boundary", 32'(EN), 32'd1);
        check("thr_after_boundary", 32'(threshold), 32'h30);
        pre_vs = 0;

        // 1000 edge pixels in one frame.
        rd_addr = 3'd2;
        d0 = done_seen;
        pixels(1000, 1'b1);
        post_vs = 1; tick(); post_vs = 0;
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("edge_cnt_1000", rd_data, 32'd1000);
        rd_addr = 3'd3; #1;
        check("frame_cnt_1", rd_data, 32'd1);
        repeat (5) tick();
        check("frame_done_count", 32'(done_seen - d0), 32'd1);

        // Mid-frame THRESH write waits for the next boundary.
        rd_addr = 3'd1;
        pulse_pre();
        reg_write(3'd1, 32'h80);
        pixels(20, 1'b1);
        check("thr_hold_midframe", 32'(threshold), 32'h30);
        pulse_post();
        check("thr_hold_after_end", 32'(threshold), 32'h30);
        pre_vs = 1; tick(); pre_vs = 0;
        check("thr_new_frame", 32'(threshold), 32'h80);

        // Single-shot: one more frame, then idle.
        reg_write(3'd0, 32'h9);
        pixels(10, 1'b1);
        d0 = done_seen;
        pulse_post();
        rd_addr = 3'd0; #1;
        check("single_ctrl_rd", rd_data, 32'h8);
        check("single_EN", 32'(EN), 32'd0);
        pulse_pre();
        pixels(20, 1'b1);
        pulse_post();
        check("single_no_second", 32'(done_seen - d0), 32'd1);

`ifdef EDGE_AUTO_TH_EN
        reg_write(3'd5, 32'd500);
        reg_write(3'd4, 32'd0);
        reg_write(3'd1, 32'd254);
        reg_write(3'd0, 32'h1);
        rd_addr = 3'd1;
        tick();
        pulse_pre();
        pixels(1000, 1'b1);
        pulse_post();
        check("auto_thr_255", rd_data, 32'd255);
        pulse_pre();
        pixels(1000, 1'b1);
        pulse_post();
        check("auto_thr_stay", rd_data, 32'd255);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) pre_vs = ~pre_vs;
            if ($urandom_range(0, 39) == 0) post_vs = ~post_vs;
            post_de  = $urandom_range(0, 1) == 1;
            post_bit = $urandom_range(0, 1) == 1;
            rd_addr  = 3'($urandom_range(0, 7));
            wr_en    = $urandom_range(0, 5) == 0;
            wr_addr  = 3'($urandom_range(0, 6));
            wr_data  = $urandom;
            if (wr_addr == 3'd0) begin
                wr_data[0] = $urandom_range(0, 3) != 0;
                wr_data[3] = $urandom_range(0, 4) == 0;
            end
            if (wr_addr == 3'd4 || wr_addr == 3'd5) wr_data = $urandom_range(0, 80);
            tick();
        end
        wr_en = 0; pre_vs = 0; post_vs = 0; post_de = 0; post_bit = 0;
        tick(); tick();

        // Asynchronous reset in the middle of a running frame.
        reg_write(3'd0, 32'h1);
        tick(); tick(); tick();
        pulse_pre();
        pixels(50, 1'b1);
        check("pre_reset_EN", 32'(EN), 32'd1);
        rst_n = 0; rd_addr = 3'd2; #1;
        check("async_rst_EN", 32'(EN), 32'd0);
        check("async_rst_thr", 32'(threshold), 32'd64);
        check("async_rst_edge", rd_data, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        pulse_pre();
        check("post_reset_idle_EN", 32'(EN), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
